// File: rtl/dpram_pkg.sv
// Shared constants and types for the byte-enable dual-port RAM.
// Write/read mode encodings and the post-reset clear FSM state type.
package dpram_pkg;

   localparam int WM_NORMAL            = 0;
   localparam int WM_WRITE_THROUGH     = 1;
   localparam int WM_READ_BEFORE_WRITE = 2;

   localparam int RM_BYPASS = 0;
   localparam int RM_PIPE   = 1;

   typedef enum logic {
      ST_CLEAR,
      ST_RUN
   } clr_state_t;

endpackage

// File: rtl/dpram_clear_ctrl.sv
// Post-reset clear engine: sweeps every address writing zero, then hands
// port A back to the user. While sweeping it owns port A's write path.
module dpram_clear_ctrl
   import dpram_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int NB             = 4,
   parameter int ADDR_W         = 10,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              i_we,
   input  logic [NB-1:0]     i_be,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_din,
   output logic              o_busy,
   output logic              o_we,
   output logic [NB-1:0]     o_be,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_din
);

   clr_state_t        r_state;
   clr_state_t        w_state_nxt;
   logic [ADDR_W-1:0] r_cnt;
   logic [ADDR_W-1:0] w_cnt_nxt;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_busy      = 1'b0;
      o_we        = i_we;
      o_be        = i_be;
      o_addr      = i_addr;
      o_din       = i_din;
      case (r_state)
         ST_CLEAR: begin
            o_busy    = 1'b1;
            o_we      = 1'b1;
            o_be      = '1;
            o_addr    = r_cnt;
            o_din     = '0;
            w_cnt_nxt = r_cnt + ADDR_W'(1);
            // last address is written on this cycle, run starts next
            if (r_cnt == '1) w_state_nxt = ST_RUN;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dpram_bwe.sv
// Single-clock true dual-port RAM with per-byte write enables, per-port
// write mode, optional output register, post-reset clear and collision flag.
module dpram_bwe
   import dpram_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int BYTE_W         = 8,
   parameter int ADDR_W         = 10,
   parameter int READ_MODE      = 0,
   parameter int WRITE_MODE_A   = 0,
   parameter int WRITE_MODE_B   = 0,
   parameter int CLEAR_ON_RESET = 1,
   localparam int NB            = DATA_W / BYTE_W
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cea,
   input  logic              ocea,
   input  logic              wrea,
   input  logic [NB-1:0]     bea,
   input  logic [ADDR_W-1:0] ada,
   input  logic [DATA_W-1:0] dina,
   output logic [DATA_W-1:0] douta,
   input  logic              ceb,
   input  logic              oceb,
   input  logic              wreb,
   input  logic [NB-1:0]     beb,
   input  logic [ADDR_W-1:0] adb,
   input  logic [DATA_W-1:0] dinb,
   output logic [DATA_W-1:0] doutb,
   output logic              busy,
   output logic              collision
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_busy;
   logic              w_wea;
   logic [NB-1:0]     w_bea;
   logic [ADDR_W-1:0] w_ada;
   logic [DATA_W-1:0] w_dina;
   logic              w_wa_usr;
   logic              w_wb;
   logic              w_same;
   logic [DATA_W-1:0] w_old_a, w_old_b;
   logic [DATA_W-1:0] w_fin_a, w_fin_b;
   logic [DATA_W-1:0] w_qa_nxt, w_qb_nxt;
   logic [DATA_W-1:0] r_qa, r_qb, r_pa, r_pb;
   logic              r_coll;

   dpram_clear_ctrl #(
      .DATA_W        (DATA_W),
      .NB            (NB),
      .ADDR_W        (ADDR_W),
      .CLEAR_ON_RESET(CLEAR_ON_RESET)
   ) u_clr (
      .clk   (clk),
      .resetn(resetn),
      .i_we  (cea & wrea),
      .i_be  (bea),
      .i_addr(ada),
      .i_din (dina),
      .o_busy(w_busy),
      .o_we  (w_wea),
      .o_be  (w_bea),
      .o_addr(w_ada),
      .o_din (w_dina)
   );

   assign w_wa_usr = cea & wrea & ~w_busy;
   assign w_wb     = ceb & wreb & ~w_busy;
   assign w_same   = (w_ada == adb);
   assign w_old_a  = r_mem[w_ada];
   assign w_old_b  = r_mem[adb];

   // Final word seen at each port's address; on overlapping bytes A wins.
   always_comb begin
      w_fin_a = w_old_a;
      w_fin_b = w_old_b;
      for (int i = 0; i < NB; i++) begin
         if (w_wb && w_same && beb[i]) w_fin_a[i*BYTE_W +: BYTE_W] = dinb[i*BYTE_W +: BYTE_W];
         if (w_wea && w_bea[i])        w_fin_a[i*BYTE_W +: BYTE_W] = w_dina[i*BYTE_W +: BYTE_W];
         if (w_wb && beb[i])           w_fin_b[i*BYTE_W +: BYTE_W] = dinb[i*BYTE_W +: BYTE_W];
         if (w_wea && w_same && w_bea[i])
            w_fin_b[i*BYTE_W +: BYTE_W] = w_dina[i*BYTE_W +: BYTE_W];
      end
   end

   // Port A is applied last so it overrides B on shared bytes.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (w_wb && beb[i])    r_mem[adb][i*BYTE_W +: BYTE_W]   <= dinb[i*BYTE_W +: BYTE_W];
         if (w_wea && w_bea[i]) r_mem[w_ada][i*BYTE_W +: BYTE_W] <= w_dina[i*BYTE_W +: BYTE_W];
      end
   end

   always_comb begin
      w_qa_nxt = r_qa;
      if (w_busy) begin
         w_qa_nxt = '0;
      end else if (cea) begin
         if (!wrea) begin
            w_qa_nxt = w_old_a;
         end else begin
            case (WRITE_MODE_A)
               WM_WRITE_THROUGH:     w_qa_nxt = w_fin_a;
               WM_READ_BEFORE_WRITE: w_qa_nxt = w_old_a;
               default:              w_qa_nxt = r_qa;
            endcase
         end
      end
   end

   always_comb begin
      w_qb_nxt = r_qb;
      if (w_busy) begin
         w_qb_nxt = '0;
      end else if (ceb) begin
         if (!wreb) begin
            w_qb_nxt = w_old_b;
         end else begin
            case (WRITE_MODE_B)
               WM_WRITE_THROUGH:     w_qb_nxt = w_fin_b;
               WM_READ_BEFORE_WRITE: w_qb_nxt = w_old_b;
               default:              w_qb_nxt = r_qb;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_qa   <= '0;
         r_qb   <= '0;
         r_pa   <= '0;
         r_pb   <= '0;
         r_coll <= 1'b0;
      end else begin
         r_qa   <= w_qa_nxt;
         r_qb   <= w_qb_nxt;
         if (ocea) r_pa <= r_qa;
         if (oceb) r_pb <= r_qb;
         r_coll <= w_wa_usr & w_wb & w_same;
      end
   end

   assign douta     = (READ_MODE == RM_PIPE) ? r_pa : r_qa;
   assign doutb     = (READ_MODE == RM_PIPE) ? r_pb : r_qb;
   assign busy      = w_busy;
   assign collision = r_coll;

endmodule

// File: tb/tb_dpram_bwe.sv
// Bench for dpram_bwe: four instances (normal / write-through / read-before-write
// / pipelined) share one stimulus stream; expectations come from a vector table.
module tb_dpram_bwe;

   logic        clk = 1'b0;
   logic        resetn;
   logic        cea, ocea, wrea, ceb, oceb, wreb;
   logic [3:0]  bea, beb, ada, adb;
   logic [31:0] dina, dinb;

   logic [31:0] douta_n, doutb_n, douta_wt, doutb_wt, douta_rb, doutb_rb, douta_p, doutb_p;
   logic        busy_n, busy_wt, busy_rb, busy_p;
   logic        coll_n, coll_wt, coll_rb, coll_p;

   int n_tot = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   dpram_bwe #(.DATA_W(32), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE_A(0), .WRITE_MODE_B(0)) u_n (
      .clk(clk), .resetn(resetn), .cea(cea), .ocea(ocea), .wrea(wrea), .bea(bea), .ada(ada),
      .dina(dina), .douta(douta_n), .ceb(ceb), .oceb(oceb), .wreb(wreb), .beb(beb), .adb(adb),
      .dinb(dinb), .doutb(doutb_n), .busy(busy_n), .collision(coll_n));
   dpram_bwe #(.DATA_W(32), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE_A(1), .WRITE_MODE_B(1)) u_wt (
      .clk(clk), .resetn(resetn), .cea(cea), .ocea(ocea), .wrea(wrea), .bea(bea), .ada(ada),
      .dina(dina), .douta(douta_wt), .ceb(ceb), .oceb(oceb), .wreb(wreb), .beb(beb), .adb(adb),
      .dinb(dinb), .doutb(doutb_wt), .busy(busy_wt), .collision(coll_wt));
   dpram_bwe #(.DATA_W(32), .ADDR_W(4), .READ_MODE(0), .WRITE_MODE_A(2), .WRITE_MODE_B(2)) u_rb (
      .clk(clk), .resetn(resetn), .cea(cea), .ocea(ocea), .wrea(wrea), .bea(bea), .ada(ada),
      .dina(dina), .douta(douta_rb), .ceb(ceb), .oceb(oceb), .wreb(wreb), .beb(beb), .adb(adb),
      .dinb(dinb), .doutb(doutb_rb), .busy(busy_rb), .collision(coll_rb));
   dpram_bwe #(.DATA_W(32), .ADDR_W(4), .READ_MODE(1), .WRITE_MODE_A(0), .WRITE_MODE_B(0)) u_p (
      .clk(clk), .resetn(resetn), .cea(cea), .ocea(ocea), .wrea(wrea), .bea(bea), .ada(ada),
      .dina(dina), .douta(douta_p), .ceb(ceb), .oceb(oceb), .wreb(wreb), .beb(beb), .adb(adb),
      .dinb(dinb), .doutb(doutb_p), .busy(busy_p), .collision(coll_p));

   typedef struct {
      logic        ca, wa;
      logic [3:0]  bea, ada;
      logic [31:0] da;
      logic        cb, wb;
      logic [3:0]  beb, adb;
      logic [31:0] db;
      logic [31:0] an, awt, arb, bn, bwt, brb, pa, pb;
      logic        coll;
   } vec_t;

   vec_t        tbl [14];
   vec_t        sb [$];
   logic [31:0] prev_an = '0;
   logic [31:0] prev_bn = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic ca, wa, input logic [3:0] ba, aa, input logic [31:0] da,
                               input logic cb, wb, input logic [3:0] bb, ab, input logic [31:0] db,
                               input logic [31:0] an, awt, arb, bn, bwt, brb, input logic coll);
      vec_t v;
      v.ca = ca; v.wa = wa; v.bea = ba; v.ada = aa; v.da = da;
      v.cb = cb; v.wb = wb; v.beb = bb; v.adb = ab; v.db = db;
      v.an = an; v.awt = awt; v.arb = arb; v.bn = bn; v.bwt = bwt; v.brb = brb;
      v.pa = '0; v.pb = '0; v.coll = coll;
      return v;
   endfunction

   task automatic idle();
      cea = 0; wrea = 0; bea = '0; ada = '0; dina = '0; ocea = 1;
      ceb = 0; wreb = 0; beb = '0; adb = '0; dinb = '0; oceb = 1;
   endtask

   task automatic check_sb();
      vec_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      chk($sformatf("douta_n a%0d", e.ada), douta_n, e.an);
      chk($sformatf("douta_wt a%0d", e.ada), douta_wt, e.awt);
      chk($sformatf("douta_rb a%0d", e.ada), douta_rb, e.arb);
      chk($sformatf("doutb_n b%0d", e.adb), doutb_n, e.bn);
      chk($sformatf("doutb_wt b%0d", e.adb), doutb_wt, e.bwt);
      chk($sformatf("doutb_rb b%0d", e.adb), doutb_rb, e.brb);
      chk("douta_p", douta_p, e.pa);
      chk("doutb_p", doutb_p, e.pb);
      chk("collision_n", 32'(coll_n), 32'(e.coll));
      chk("collision_wt", 32'(coll_wt), 32'(e.coll));
      chk("busy_run", 32'({busy_n, busy_wt, busy_rb, busy_p}), 32'd0);
   endtask

   // Drive at a falling edge; the result is checked at the next falling edge.
   task automatic step(input vec_t v);
      v.pa = prev_an; v.pb = prev_bn;
      prev_an = v.an; prev_bn = v.bn;
      cea = v.ca; wrea = v.wa; bea = v.bea; ada = v.ada; dina = v.da; ocea = 1;
      ceb = v.cb; wreb = v.wb; beb = v.beb; adb = v.adb; dinb = v.db; oceb = 1;
      sb.push_back(v);
      @(negedge clk);
      check_sb();
   endtask

   task automatic count_busy(output int n, input int stop_at, input logic poke);
      n = 0;
      while (busy_n === 1'b1 && n < 40 && n != stop_at) begin
         if (poke && n == 3) begin
            cea = 1; wrea = 1; bea = 4'hF; ada = 4'd1; dina = 32'hFFFF_FFFF;
            ceb = 1; wreb = 1; beb = 4'hF; adb = 4'd1; dinb = 32'hEEEE_EEEE;
         end
         if (poke && n == 5) idle();
         chk("busy_douta_wt", douta_wt, 32'd0);
         chk("busy_collision", 32'(coll_n), 32'd0);
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      idle();
      resetn = 0;
      tbl[0]  = mk(1,1,4'hF,4'd3,32'hDEADBEEF, 0,0,4'h0,4'd0,32'h0,
                   32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 0);
      tbl[1]  = mk(1,1,4'h5,4'd3,32'h11223344, 0,0,4'h0,4'd0,32'h0,
                   32'h0, 32'hDE22BE44, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 0);
      tbl[2]  = mk(0,0,4'h0,4'd0,32'h0, 1,0,4'h0,4'd3,32'h0,
                   32'h0, 32'hDE22BE44, 32'hDEADBEEF, 32'hDE22BE44, 32'hDE22BE44, 32'hDE22BE44, 0);
      tbl[3]  = mk(1,1,4'hF,4'd5,32'h12345678, 1,1,4'hF,4'd9,32'hCAFEF00D,
                   32'h0, 32'h12345678, 32'h0, 32'hDE22BE44, 32'hCAFEF00D, 32'h0, 0);
      tbl[4]  = mk(1,1,4'h3,4'd5,32'hAAAA5555, 1,0,4'h0,4'd5,32'h0,
                   32'h0, 32'h12345555, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 0);
      tbl[5]  = mk(1,0,4'h0,4'd5,32'h0, 1,0,4'h0,4'd9,32'h0,
                   32'h12345555, 32'h12345555, 32'h12345555, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 0);
      tbl[6]  = mk(1,1,4'h1,4'd7,32'h000000AA, 1,1,4'h3,4'd7,32'h0000BBCC,
                   32'h12345555, 32'h0000BBAA, 32'h0, 32'hCAFEF00D, 32'h0000BBAA, 32'h0, 1);
      tbl[7]  = mk(1,0,4'h0,4'd7,32'h0, 0,0,4'h0,4'd0,32'h0,
                   32'h0000BBAA, 32'h0000BBAA, 32'h0000BBAA, 32'hCAFEF00D, 32'h0000BBAA, 32'h0, 0);
      tbl[8]  = mk(1,1,4'h6,4'd2,32'h11111111, 1,1,4'hC,4'd2,32'h22222222,
                   32'h0000BBAA, 32'h22111100, 32'h0, 32'hCAFEF00D, 32'h22111100, 32'h0, 1);
      tbl[9]  = mk(1,1,4'hF,4'd4,32'h44444444, 1,1,4'hF,4'd6,32'h66666666,
                   32'h0000BBAA, 32'h44444444, 32'h0, 32'hCAFEF00D, 32'h66666666, 32'h0, 0);
      tbl[10] = mk(1,0,4'h0,4'd2,32'h0, 1,0,4'h0,4'd4,32'h0,
                   32'h22111100, 32'h22111100, 32'h22111100, 32'h44444444, 32'h44444444, 32'h44444444, 0);
      tbl[11] = mk(1,1,4'h0,4'd6,32'hFFFFFFFF, 1,0,4'h0,4'd6,32'h0,
                   32'h22111100, 32'h66666666, 32'h66666666, 32'h66666666, 32'h66666666, 32'h66666666, 0);
      tbl[12] = mk(1,0,4'h0,4'd6,32'h0, 0,1,4'hF,4'd0,32'h0BADBAD0,
                   32'h66666666, 32'h66666666, 32'h66666666, 32'h66666666, 32'h66666666, 32'h66666666, 0);
      tbl[13] = mk(1,0,4'h0,4'd9,32'h0, 1,0,4'h0,4'd0,32'h0,
                   32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0, 32'h0, 32'h0, 0);

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_douta", douta_n, 32'd0);
      chk("rst_doutb", doutb_n, 32'd0);
      chk("rst_collision", 32'(coll_n), 32'd0);
      chk("rst_busy", 32'(busy_n), 32'd1);

      // clear sweep, with writes attempted while busy
      resetn = 1;
      count_busy(n, -1, 1'b1);
      chk("clear_cycles", 32'(n), 32'd16);
      idle();

      for (int i = 0; i < 16; i++)
         step(mk(1,0,4'h0,4'(i),32'h0, 1,0,4'h0,4'(15-i),32'h0, 0,0,0,0,0,0, 0));

      for (int i = 0; i < 14; i++) step(tbl[i]);

      // output-register latency and hold
      cea = 1; wrea = 0; ada = 4'd3; ocea = 1; ceb = 0;
      @(negedge clk);
      chk("bypass_lat1", douta_n, 32'hDE22BE44);
      chk("pipe_lat1", douta_p, 32'hCAFEF00D);
      @(negedge clk);
      chk("pipe_lat2", douta_p, 32'hDE22BE44);
      ada = 4'd7; ocea = 0;
      repeat (2) @(negedge clk);
      chk("pipe_hold", douta_p, 32'hDE22BE44);
      cea = 0; ocea = 1;
      @(negedge clk);
      chk("pipe_resume", douta_p, 32'h0000BBAA);
      idle();

      // reset in run, then again partway through the clear
      resetn = 0;
      #1;
      chk("async_rst_douta_n", douta_n, 32'd0);
      chk("async_rst_doutb_n", doutb_n, 32'd0);
      chk("async_rst_douta_p", douta_p, 32'd0);
      chk("async_rst_busy", 32'(busy_n), 32'd1);
      @(negedge clk);
      resetn = 1;
      count_busy(n, 9, 1'b0);
      chk("partial_clear", 32'(n), 32'd9);
      resetn = 0;
      #1;
      chk("midclear_rst_douta", douta_wt, 32'd0);
      chk("midclear_rst_busy", 32'(busy_n), 32'd1);
      @(negedge clk);
      resetn = 1;
      count_busy(n, -1, 1'b0);
      chk("reclear_cycles", 32'(n), 32'd16);
      prev_an = '0; prev_bn = '0;
      step(mk(1,0,4'h0,4'd3,32'h0, 1,0,4'h0,4'd7,32'h0, 0,0,0,0,0,0, 0));
      step(mk(1,0,4'h0,4'd9,32'h0, 1,0,4'h0,4'd2,32'h0, 0,0,0,0,0,0, 0));

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
